// File: rtl/bus_arb_pkg.sv
// Shared types and width helpers for the bus arbiters.
package bus_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GRANT = 2'd1,
      ST_TURN  = 2'd2
   } arb_state_e;

   localparam int TA_W = 3;

   // Counter width able to hold 0..max_t without wrapping; at least one bit.
   function automatic int tenure_width(input int max_t);
      return (max_t > 0) ? $clog2(max_t + 1) : 1;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority encoder: first set bit of req scanning from rr_ptr upward with wrap.
module rr_pick #(
   parameter int N  = 4,
   parameter int IW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] rr_ptr,
   output logic          any,
   output logic [IW-1:0] idx
);

   int            sum_s;
   logic [IW-1:0] pos_s;

   // Scan from the far end back toward rr_ptr so the last hit is the highest-priority one.
   always_comb begin
      any   = |req;
      idx   = '0;
      sum_s = 0;
      pos_s = '0;
      for (int i = N - 1; i >= 0; i--) begin
         sum_s = int'(rr_ptr) + i;
         pos_s = IW'((sum_s >= N) ? (sum_s - N) : sum_s);
         idx   = req[pos_s] ? pos_s : idx;
      end
   end

endmodule

// File: rtl/bus_rr_arbiter.sv
// Round-robin bus arbiter with bounded tenure, optional turnaround gap and registered outputs.
module bus_rr_arbiter
   import bus_arb_pkg::*;
#(
   parameter int NUM_REQ    = 4,
   parameter int MAX_TENURE = 16,
   parameter int TURNAROUND = 1
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [NUM_REQ-1:0]         req,
   output logic [NUM_REQ-1:0]         grant,
   output logic                       grant_valid,
   output logic [$clog2(NUM_REQ)-1:0] owner_id,
   output logic                       preempt
);

   localparam int IW    = $clog2(NUM_REQ);
   localparam int TEN_W = tenure_width(MAX_TENURE);
   localparam logic [TEN_W-1:0] TEN_MAX = TEN_W'(MAX_TENURE);
   localparam logic [TA_W-1:0]  TA_LAST = TA_W'(TURNAROUND);

   arb_state_e          state_r, state_s;
   logic [IW-1:0]       rr_ptr_r, rr_ptr_s;
   logic [IW-1:0]       owner_r, owner_s;
   logic [TEN_W-1:0]    tenure_r, tenure_s;
   logic [TA_W-1:0]     ta_cnt_r, ta_cnt_s;
   logic [NUM_REQ-1:0]  grant_r, grant_s;
   logic                grant_valid_r;
   logic                preempt_r, preempt_s;

   logic                pick_any_s;
   logic [IW-1:0]       pick_idx_s;
   logic [IW-1:0]       pick_ptr_s;
   logic [IW-1:0]       next_ptr_s;
   logic [NUM_REQ-1:0]  pick_oh_s;
   logic                owner_req_s;
   logic                others_s;
   logic                expire_s;

   rr_pick #(.N(NUM_REQ), .IW(IW)) u_pick (
      .req    (req),
      .rr_ptr (pick_ptr_s),
      .any    (pick_any_s),
      .idx    (pick_idx_s)
   );

   // Release-side helpers; while granting, the pick already starts after the owner for zero-gap handoff.
   always_comb begin
      next_ptr_s   = (owner_r == IW'(NUM_REQ - 1)) ? '0 : (owner_r + IW'(1));
      pick_ptr_s   = (state_r == ST_GRANT) ? next_ptr_s : rr_ptr_r;
      pick_oh_s    = '0;
      pick_oh_s[pick_idx_s] = 1'b1;
      owner_req_s  = req[owner_r];
      others_s     = |(req & ~grant_r);
      expire_s     = (MAX_TENURE != 0) && (tenure_r == TEN_MAX) && owner_req_s && others_s;
   end

   // Next-state, counter and output decode.
   always_comb begin
      state_s   = state_r;
      rr_ptr_s  = rr_ptr_r;
      owner_s   = owner_r;
      tenure_s  = tenure_r;
      ta_cnt_s  = ta_cnt_r;
      grant_s   = grant_r;
      preempt_s = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (pick_any_s) begin
               grant_s  = pick_oh_s;
               owner_s  = pick_idx_s;
               tenure_s = TEN_W'(1);
               state_s  = ST_GRANT;
            end else begin
               grant_s  = '0;
            end
         end
         ST_GRANT: begin
            if (!owner_req_s || expire_s) begin
               grant_s   = '0;
               rr_ptr_s  = next_ptr_s;
               preempt_s = expire_s;
               if (TURNAROUND > 0) begin
                  state_s  = ST_TURN;
                  ta_cnt_s = TA_W'(1);
               end else if (pick_any_s) begin
                  grant_s  = pick_oh_s;
                  owner_s  = pick_idx_s;
                  tenure_s = TEN_W'(1);
                  state_s  = ST_GRANT;
               end else begin
                  state_s  = ST_IDLE;
               end
            end else begin
               if ((MAX_TENURE != 0) && (tenure_r != TEN_MAX)) begin
                  tenure_s = tenure_r + TEN_W'(1);
               end else begin
                  tenure_s = tenure_r;
               end
            end
         end
         ST_TURN: begin
            grant_s = '0;
            if (ta_cnt_r >= TA_LAST) begin
               if (pick_any_s) begin
                  grant_s  = pick_oh_s;
                  owner_s  = pick_idx_s;
                  tenure_s = TEN_W'(1);
                  state_s  = ST_GRANT;
               end else begin
                  state_s  = ST_IDLE;
               end
            end else begin
               ta_cnt_s = ta_cnt_r + TA_W'(1);
            end
         end
         default: begin
            state_s = ST_IDLE;
            grant_s = '0;
         end
      endcase
   end

   // State, counters and registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r       <= ST_IDLE;
         rr_ptr_r      <= '0;
         owner_r       <= '0;
         tenure_r      <= '0;
         ta_cnt_r      <= '0;
         grant_r       <= '0;
         grant_valid_r <= 1'b0;
         preempt_r     <= 1'b0;
      end else begin
         state_r       <= state_s;
         rr_ptr_r      <= rr_ptr_s;
         owner_r       <= owner_s;
         tenure_r      <= tenure_s;
         ta_cnt_r      <= ta_cnt_s;
         grant_r       <= grant_s;
         grant_valid_r <= |grant_s;
         preempt_r     <= preempt_s;
      end
   end

   assign grant       = grant_r;
   assign grant_valid = grant_valid_r;
   assign owner_id    = owner_r;
   assign preempt     = preempt_r;

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Directed bench for bus_rr_arbiter with NUM_REQ=4, MAX_TENURE=4, TURNAROUND=1.
module tb_bus_rr_arbiter;

   logic       clk;
   logic       reset;
   logic [3:0] req;
   logic [3:0] grant;
   logic       grant_valid;
   logic [1:0] owner_id;
   logic       preempt;

   int checks = 0;
   int errors = 0;

   bus_rr_arbiter #(.NUM_REQ(4), .MAX_TENURE(4), .TURNAROUND(1)) dut (
      .clk         (clk),
      .reset       (reset),
      .req         (req),
      .grant       (grant),
      .grant_valid (grant_valid),
      .owner_id    (owner_id),
      .preempt     (preempt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [3:0] eg, input logic [1:0] eo, input logic ep);
      checks++;
      assert (grant === eg && grant_valid === (|eg) && owner_id === eo && preempt === ep)
      else begin
         errors++;
         $error("FAIL %s grant=%b gv=%b owner=%0d preempt=%b expected grant=%b gv=%b owner=%0d preempt=%b",
                tag, grant, grant_valid, owner_id, preempt, eg, |eg, eo, ep);
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      req   = 4'b0000;
      tick();
      tick();
      chk("reset", 4'b0000, 2'd0, 1'b0);
      reset = 1'b0;
   endtask

   initial begin
      logic [3:0] exp_g;
      reset = 1'b1;
      req   = 4'b0000;

      // 1. single request
      do_reset();
      req = 4'b0001;
      tick(); chk("single_grant", 4'b0001, 2'd0, 1'b0);
      tick(); chk("single_hold", 4'b0001, 2'd0, 1'b0);
      req = 4'b0000;
      tick(); chk("single_rel", 4'b0000, 2'd0, 1'b0);
      tick(); chk("single_idle", 4'b0000, 2'd0, 1'b0);

      // 2. round-robin rotation
      do_reset();
      req = 4'b1111;
      tick();
      for (int i = 0; i < 4; i++) begin
         exp_g = 4'b0001 << i;
         chk("rr_grant", exp_g, 2'(i), 1'b0);
         tick(); chk("rr_hold", exp_g, 2'(i), 1'b0);
         req[i] = 1'b0;
         tick(); chk("rr_gap", 4'b0000, 2'(i), 1'b0);
         tick();
      end
      chk("rr_idle", 4'b0000, 2'd3, 1'b0);

      // 3. preemption at tenure expiry
      do_reset();
      req = 4'b0001;
      tick(); chk("pre_c1", 4'b0001, 2'd0, 1'b0);
      tick(); chk("pre_c2", 4'b0001, 2'd0, 1'b0);
      req = 4'b0101;
      tick(); chk("pre_c3", 4'b0001, 2'd0, 1'b0);
      tick(); chk("pre_c4", 4'b0001, 2'd0, 1'b0);
      tick(); chk("pre_gap", 4'b0000, 2'd0, 1'b1);
      tick(); chk("pre_next", 4'b0100, 2'd2, 1'b0);
      tick(); chk("pre_after", 4'b0100, 2'd2, 1'b0);

      // 4. lone long owner
      do_reset();
      req = 4'b0010;
      for (int i = 0; i < 30; i++) begin
         tick(); chk("lone_hold", 4'b0010, 2'd1, 1'b0);
      end
      req = 4'b0000;
      tick(); chk("lone_rel", 4'b0000, 2'd1, 1'b0);
      tick(); chk("lone_idle", 4'b0000, 2'd1, 1'b0);

      // 5. reset mid-grant, then rr_ptr back at 0
      do_reset();
      req = 4'b0100;
      tick(); chk("mid_grant", 4'b0100, 2'd2, 1'b0);
      tick();
      reset = 1'b1;
      tick(); chk("mid_reset", 4'b0000, 2'd0, 1'b0);
      reset = 1'b0;
      req   = 4'b1111;
      tick(); chk("mid_after", 4'b0001, 2'd0, 1'b0);

      // 6. owner releases in the expiry cycle
      tick(); chk("exp_c2", 4'b0001, 2'd0, 1'b0);
      tick(); chk("exp_c3", 4'b0001, 2'd0, 1'b0);
      tick(); chk("exp_c4", 4'b0001, 2'd0, 1'b0);
      req = 4'b1110;
      tick(); chk("exp_rel", 4'b0000, 2'd0, 1'b0);
      tick(); chk("exp_next", 4'b0010, 2'd1, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
